// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding and opcode constants for the 16-bit CPU.
package cpu_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT} seq_state_t;
    localparam logic [4:0] OP_LD = 5'b00100;
    localparam logic [4:0] OP_ST = 5'b00101;
    function automatic logic is_mem_state(input seq_state_t s);
        return s == FETCH || s == MEM;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request waits; expired fires on the last allowed wait cycle.
module mem_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = LIMIT > 1 ? $clog2(LIMIT + 1) : 1;
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset || clear_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + W'(1);
    end
    // LIMIT of zero disables the watchdog entirely
    assign expired_o = (LIMIT != 0) && en_i && (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with a shared memory port and timeout watchdog.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             dec_reg_write,
    input  logic             dec_mem_write,
    input  logic             dec_mem_read,
    input  logic             dec_nz,
    input  logic             dec_pc_enable,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             rf_we,
    output logic             nz_we,
    output logic             pc_we,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);
    seq_state_t state_q, state_d;
    logic mem_req_q, mem_sel_q, busy_q, fault_q, expired;
    logic [CNT_W-1:0] cnt_q;

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!mem_req_q),
        .en_i      (mem_req_q && !mem_ready),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? FETCH : IDLE;
            FETCH:   state_d = mem_ready ? DECODE : expired ? FAULT : FETCH;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = (dec_mem_read || dec_mem_write) ? MEM : WB;
            MEM:     state_d = mem_ready ? WB : expired ? FAULT : MEM;
            WB:      state_d = run ? FETCH : IDLE;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= is_mem_state(state_d);
            mem_sel_q <= state_d == MEM;
            busy_q    <= state_d != IDLE && state_d != FAULT;
            fault_q   <= state_d == FAULT;
            if (state_q == WB) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // strobes decode the registered state; load strobes also need the accepting ready
    assign mem_req     = mem_req_q;
    assign mem_sel     = mem_sel_q;
    assign mem_we      = mem_sel_q && dec_mem_write;
    assign ir_load     = mem_req_q && !mem_sel_q && mem_ready;
    assign mdr_load    = mem_sel_q && mem_ready && dec_mem_read;
    assign rf_we       = state_q == WB && dec_reg_write;
    assign nz_we       = state_q == WB && dec_nz;
    assign pc_we       = state_q == WB && dec_pc_enable;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream with a per-instruction scoreboard, plus reset and timeout scenarios.
module tb_cpu_sequencer;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic reset, run, dec_reg_write, dec_mem_write, dec_mem_read, dec_nz, dec_pc_enable, mem_ready;
    logic mem_req, mem_sel, mem_we, ir_load, mdr_load, rf_we, nz_we, pc_we, busy, fault;
    logic [CW-1:0] instr_count;

    cpu_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run),
        .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write), .dec_mem_read(dec_mem_read),
        .dec_nz(dec_nz), .dec_pc_enable(dec_pc_enable), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_load(ir_load), .mdr_load(mdr_load),
        .rf_we(rf_we), .nz_we(nz_we), .pc_we(pc_we), .busy(busy), .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {int ir; int mdr; int we; int rf; int nz; int pc; int lat; int cnt;} rec_t;
    rec_t exp_q[$];
    rec_t acc;
    int n_pass = 0, n_tot = 0;
    logic [CW-1:0] model_cnt = '0;
    logic [CW-1:0] last_cnt = '0;

    function automatic void chk(input string name, input int act, input int req);
        n_tot++;
        if (act !== req) $display("FAIL %s: got %0d expected %0d", name, act, req);
        else n_pass++;
    endfunction

    function automatic int outs_vec();
        return int'({mem_req, mem_sel, mem_we, ir_load, mdr_load, rf_we, nz_we, pc_we, busy, fault});
    endfunction

    always @(negedge clk) begin
        rec_t e;
        if (reset) begin
            last_cnt = '0;
            acc = '{default: 0};
        end else begin
            if (instr_count != last_cnt) begin
                if (exp_q.size() == 0) chk("spurious_retire", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("ir_load_pulses", acc.ir, e.ir);
                    chk("mdr_load_pulses", acc.mdr, e.mdr);
                    chk("mem_we_cycles", acc.we, e.we);
                    chk("rf_we_pulses", acc.rf, e.rf);
                    chk("nz_we_pulses", acc.nz, e.nz);
                    chk("pc_we_pulses", acc.pc, e.pc);
                    chk("latency", acc.lat, e.lat);
                    chk("instr_count", int'(instr_count), e.cnt);
                end
                last_cnt = instr_count;
                acc = '{default: 0};
            end
            acc.ir  += int'(ir_load);
            acc.mdr += int'(mdr_load);
            acc.we  += int'(mem_we);
            acc.rf  += int'(rf_we);
            acc.nz  += int'(nz_we);
            acc.pc  += int'(pc_we);
            acc.lat += int'(busy);
            chk("invariant", int'((mem_we && !mem_sel) ||
                (!busy && (ir_load || mdr_load || rf_we || nz_we || pc_we || mem_we))), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic find_req(input logic sel);
        int n = 0;
        while (!(mem_req && mem_sel == sel) && n < 20) begin
            mem_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("req_seen", n < 20 ? 1 : 0, 1);
    endtask

    task automatic serve(input int w);
        repeat (w) begin
            mem_ready = 1'b0;
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic do_instr(input logic rw, mw, mr, nz, pce, input int fw, dw, input logic drop);
        rec_t e;
        int n = 0;
        model_cnt = model_cnt + 1'b1;
        e.ir = 1;
        e.mdr = int'(mr);
        e.we = mw ? dw + 1 : 0;
        e.rf = int'(rw);
        e.nz = int'(nz);
        e.pc = int'(pce);
        e.lat = (fw + 1) + 3 + ((mr || mw) ? dw + 1 : 0);
        e.cnt = int'(model_cnt);
        exp_q.push_back(e);
        run = 1'b1;
        find_req(1'b0);
        {dec_reg_write, dec_mem_write, dec_mem_read, dec_nz, dec_pc_enable} = {rw, mw, mr, nz, pce};
        serve(fw);
        if (drop) run = 1'b0;
        if (mr || mw) begin
            find_req(1'b1);
            serve(dw);
        end
        if (drop) begin
            while (busy && n < 10) begin
                step();
                n++;
            end
            chk("idle_after_drop", int'(busy), 0);
            repeat ($urandom_range(0, 2)) step();
            run = 1'b1;
            step();
            chk("refetch_after_run", int'(mem_req && !mem_sel && busy), 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k, fw, dw;
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
        {dec_reg_write, dec_mem_write, dec_mem_read, dec_nz, dec_pc_enable} = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_outputs", outs_vec(), 0);
        chk("reset_count", int'(instr_count), 0);
        do_instr(1, 0, 0, 0, 1, 0, 0, 0);
        do_instr(1, 0, 1, 0, 1, 0, 3, 0);
        do_instr(0, 1, 0, 0, 1, 0, 2, 0);
        do_instr(1, 0, 0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            fw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            do_instr(1'($urandom_range(0, 1)), k == 2, k == 1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), fw, dw, $urandom_range(0, 4) == 0);
        end
        run = 1'b1;
        find_req(1'b0);
        {dec_reg_write, dec_mem_write, dec_mem_read, dec_nz, dec_pc_enable} = 5'b10101;
        serve(0);
        find_req(1'b1);
        mem_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run = 1'b0;
        model_cnt = '0;
        chk("abort_mem_req", int'(mem_req), 0);
        chk("abort_idle", int'(busy), 0);
        mem_ready = 1'b1;
        repeat (3) begin
            step();
            chk("late_ready_no_strobe", int'({ir_load, mdr_load, rf_we, nz_we, pc_we, mem_we}), 0);
        end
        mem_ready = 1'b0;
        run = 1'b1;
        step();
        chk("fetch_start", int'(mem_req && !mem_sel), 1);
        repeat (4) begin
            chk("fetch_wait_req", int'(mem_req), 1);
            step();
        end
        chk("fault_set", int'(fault), 1);
        chk("fault_mem_req", int'(mem_req), 0);
        chk("fault_busy", int'(busy), 0);
        mem_ready = 1'b1;
        repeat (4) step();
        chk("fault_sticky", int'(fault && !mem_req), 1);
        run = 1'b0;
        mem_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("post_fault_reset_outputs", outs_vec(), 0);
        chk("post_fault_reset_count", int'(instr_count), 0);
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
